// File: rtl/gate_pkg.sv
// gate_pkg
//   Shared constants for the gate-stage blocks and their benches.
//   No ports. Holds the default synchroniser depth, debounce window and
//   counter width, the short debounce window used in simulation, and a
//   helper that computes the terminal count of the debounce counter.
package gate_pkg;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1000;
  localparam int DEF_CNT_W           = 16;

  // Short window so gate-stage benches do not spend thousands of cycles
  // waiting for each accepted level change.
  localparam int SIM_DEBOUNCE_CYCLES = 4;

  // The counter counts 0 .. cycles-1; reaching the last value means the
  // new level has persisted for the whole window.
  function automatic int debounce_last(input int cycles);
    return cycles - 1;
  endfunction

endpackage

// File: rtl/gate_in_debounce_ch.sv
// gate_in_debounce_ch
//   One debounced input channel: synchroniser chain, stability counter,
//   registered clean level and registered single-cycle edge pulses.
// Ports:
//   clk      in   rising-edge system clock
//   rst_n    in   asynchronous active-low reset
//   raw_in   in   raw asynchronous, possibly bouncy level
//   level    out  debounced level
//   rise     out  one-cycle pulse in the cycle level first reads 1
//   fall     out  one-cycle pulse in the cycle level first reads 0
//   settled  out  synchronised input equals level and no count pending
module gate_in_debounce_ch
  import gate_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic settled
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(debounce_last(DEBOUNCE_CYCLES));

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_s;
  logic                   mismatch;

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign mismatch = (sync_s != level_q);

  // The counter only runs while the synchronised input disagrees with the
  // accepted level; any agreement (including a bounce back) restarts the
  // window from zero. Hitting the terminal count accepts the new level and
  // clears the counter, so it can never wrap.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_in};
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (mismatch) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_s;
        rise_d  = sync_s;
        fall_d  = ~sync_s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level   = level_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign settled = ~mismatch & (cnt_q == '0);

endmodule

// File: rtl/gate_in_debounce.sv
// gate_in_debounce
//   Two-channel input conditioner feeding the a/b inputs of a 2-input gate.
//   Each raw pin is synchronised and debounced independently; stable tells
//   downstream checkers when the gate output is meaningful.
// Ports:
//   clk            in   rising-edge system clock
//   rst_n          in   asynchronous active-low reset
//   a_raw, b_raw   in   raw asynchronous levels
//   a, b           out  debounced levels for the gate inputs
//   a_rise/a_fall  out  one-cycle edge pulses for channel A
//   b_rise/b_fall  out  one-cycle edge pulses for channel B
//   stable         out  both channels settled (reads 1 during reset)
module gate_in_debounce
  import gate_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall,
  output logic stable
);

  logic a_settled;
  logic b_settled;

  gate_in_debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_in (a_raw),
    .level  (a),
    .rise   (a_rise),
    .fall   (a_fall),
    .settled(a_settled)
  );

  gate_in_debounce_ch #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_in (b_raw),
    .level  (b),
    .rise   (b_rise),
    .fall   (b_fall),
    .settled(b_settled)
  );

  assign stable = a_settled & b_settled;

endmodule

// File: tb/tb_gate_in_debounce.sv
// tb_gate_in_debounce
//   Directed bench for gate_in_debounce with SYNC_STAGES=2 and the short
//   simulation debounce window (4). Stimulus steps push the expected output
//   vector {a,b,a_rise,a_fall,b_rise,b_fall,stable} into a scoreboard queue;
//   the vector is popped and compared one time unit after the next edge.
module tb_gate_in_debounce;
  import gate_pkg::*;

  localparam int SYNC = 2;
  localparam int DEB  = SIM_DEBOUNCE_CYCLES;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic a, b, a_rise, a_fall, b_rise, b_fall, stable;

  typedef struct {
    logic [6:0] exp;
    logic [6:0] mask;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic expA = 1'b0;
  logic expB = 1'b0;

  gate_in_debounce #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a_raw (a_raw),
    .b_raw (b_raw),
    .a     (a),
    .b     (b),
    .a_rise(a_rise),
    .a_fall(a_fall),
    .b_rise(b_rise),
    .b_fall(b_fall),
    .stable(stable)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Expected vector for the coming edge: an accepted channel flips its
  // level and shows the matching pulse; stableExp < 0 leaves stable unchecked.
  task automatic pushExpect(input logic acceptA, input logic acceptB,
                            input int stableExp, input string tag);
    exp_t e;
    logic newA, newB;
    newA = acceptA ? ~expA : expA;
    newB = acceptB ? ~expB : expB;
    e.exp  = {newA, newB, acceptA & newA, acceptA & ~newA,
              acceptB & newB, acceptB & ~newB, (stableExp > 0)};
    e.mask = (stableExp < 0) ? 7'b1111110 : 7'b1111111;
    e.tag  = tag;
    sb.push_back(e);
    expA = newA;
    expB = newB;
  endtask

  // Pops the oldest expectation and compares it with the live outputs.
  task automatic checkOutput();
    exp_t e;
    logic [6:0] obs;
    obs = {a, b, a_rise, a_fall, b_rise, b_fall, stable};
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_empty observed=%b required=an entry", obs);
    end else begin
      e = sb.pop_front();
      assert ((obs & e.mask) === (e.exp & e.mask)) else begin
        mismatched++;
        $error("[TB] FAIL %s observed=%b required=%b mask=%b", e.tag, obs, e.exp, e.mask);
      end
    end
  endtask

  // Drives one cycle of raw levels and checks the result after the edge.
  task automatic applyStimulus(input logic ra, input logic rb,
                               input logic acceptA, input logic acceptB,
                               input int stableExp, input string tag);
    a_raw = ra;
    b_raw = rb;
    pushExpect(acceptA, acceptB, stableExp, tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Immediate check of the current outputs without advancing the clock.
  task automatic checkNow(input logic [6:0] vec, input string tag);
    exp_t e;
    e.exp  = vec;
    e.mask = 7'b1111111;
    e.tag  = tag;
    sb.push_back(e);
    checkOutput();
  endtask

  // Holds constant raw levels for n edges; a channel is accepted on edge
  // accA/accB (0 = never); stable is low on edges stLo..stHi, high otherwise.
  task automatic runPhase(input string name, input logic ra, input logic rb,
                          input int n, input int accA, input int accB,
                          input int stLo, input int stHi);
    for (int i = 1; i <= n; i++) begin
      applyStimulus(ra, rb, (i == accA), (i == accB),
                    ((i >= stLo) && (i <= stHi)) ? 0 : 1,
                    $sformatf("%s_e%0d", name, i));
    end
  endtask

  logic [0:10] bouncePat = 11'b11101111111;
  logic [0:6]  glitchPat = 7'b1110000;

  initial begin
    // Reset with both raw pins high: everything cleared, stable reads 1.
    rst_n = 1'b0;
    a_raw = 1'b1;
    b_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkNow(7'b0000001, "reset_hold");
    rst_n = 1'b1;
    expA  = 1'b0;
    expB  = 1'b0;
    runPhase("release", 1'b1, 1'b1, 7, SYNC + DEB, SYNC + DEB, 2, 5);

    // Clean steps on A.
    runPhase("fallA",     1'b0, 1'b1, 7, 6, 0, 2, 5);
    runPhase("stepRiseA", 1'b1, 1'b1, 7, 6, 0, 2, 5);
    runPhase("stepFallA", 1'b0, 1'b1, 7, 6, 0, 2, 5);

    // Bounce: high 3, low 1, then high; accepted on the 6th edge of the
    // final run (edge 10 overall).
    for (int i = 1; i <= 11; i++) begin
      applyStimulus(bouncePat[i-1], 1'b1, (i == 10), 1'b0,
                    (i == 1 || i >= 10) ? 1 : 0,
                    $sformatf("bounce_e%0d", i));
    end
    runPhase("bounceFallA", 1'b0, 1'b1, 7, 6, 0, 2, 5);

    // Short glitch: three high cycles are one short of the window.
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(glitchPat[i-1], 1'b1, 1'b0, 1'b0,
                    (i == 1 || i >= 6) ? 1 : 0,
                    $sformatf("glitch_e%0d", i));
    end

    // Simultaneous change on both channels.
    runPhase("fallB",    1'b0, 1'b0, 7, 0, 6, 2, 5);
    runPhase("simRise",  1'b1, 1'b1, 7, 6, 6, 2, 5);
    runPhase("bothFall", 1'b0, 1'b0, 7, 6, 6, 2, 5);

    // Reset in the middle of a count on A (cnt_a == 2 after the 4th edge).
    runPhase("preRst", 1'b1, 1'b0, 4, 0, 0, 2, 4);
    rst_n = 1'b0;
    #1;
    checkNow(7'b0000001, "rst_mid_count");
    repeat (2) @(posedge clk);
    #1;
    checkNow(7'b0000001, "rst_mid_hold");
    rst_n = 1'b1;
    expA  = 1'b0;
    expB  = 1'b0;
    runPhase("postRst", 1'b1, 1'b0, 6, 6, 0, 2, 5);

    // Reset asserted while a_rise is high must clear level and pulse at once.
    rst_n = 1'b0;
    #1;
    checkNow(7'b0000001, "rst_during_pulse");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expA  = 1'b0;
    expB  = 1'b0;
    runPhase("final", 1'b1, 1'b0, 7, 6, 0, 2, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
